// File: rtl/vram_arbiter.sv
// Video SRAM arbiter: display fetch has priority, CPU accesses are stretched via cpu_ready.
// Optional CPU starvation guard enabled by defining VRAM_CPU_STARVE_GUARD_EN.
module vram_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int ACC_CYC  = 2,
  parameter int MAX_WAIT = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              plane,
  input  logic              blank,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic              disp_valid,
  output logic [7:0]        disp_data,
  input  logic              _cpu_cs,
  input  logic              _cpu_wr,
  input  logic [ADDR_W:0]   cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ready,
  output logic [ADDR_W:0]   vram_addr,
  output logic [7:0]        vram_wdata,
  output logic              vram_wdata_en,
  input  logic [7:0]        vram_rdata,
  output logic              _vram_oe,
  output logic              _vram_we
);
  typedef enum logic [1:0] {IDLE, DISP, CPU_RD, CPU_WR} state_t;

  state_t     state, state_nxt;
  logic [3:0] acc_cnt;
  logic       cpu_pend;
  logic       cpu_go, disp_go, guard_fire;
  logic       acc_last, cpu_busy, disp_grant, cpu_grant;

  if (ACC_CYC < 2 || ACC_CYC > 15 || MAX_WAIT < 1 || MAX_WAIT > 31) begin : g_param_chk
    $error("vram_arbiter: ACC_CYC or MAX_WAIT out of range");
  end

  assign cpu_go     = cpu_pend && !_cpu_cs;
  assign disp_go    = disp_req && !blank;
  assign cpu_busy   = (state == CPU_RD) || (state == CPU_WR);
  assign acc_last   = (state != IDLE) && (acc_cnt == 4'd1);
  assign disp_grant = (state == IDLE) && (state_nxt == DISP);
  assign cpu_grant  = (state == IDLE) && ((state_nxt == CPU_RD) || (state_nxt == CPU_WR));

`ifdef VRAM_CPU_STARVE_GUARD_EN
  logic [4:0] wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wait_cnt <= 5'd0;
    else if (cpu_grant || !cpu_pend)
      wait_cnt <= 5'd0;
    else if (cpu_go && (wait_cnt != 5'(MAX_WAIT)))
      wait_cnt <= wait_cnt + 5'd1;
  end

  assign guard_fire = cpu_go && (wait_cnt == 5'(MAX_WAIT));
`else
  assign guard_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (guard_fire || (cpu_go && !disp_go))
          state_nxt = _cpu_wr ? CPU_RD : CPU_WR;
        else if (disp_go)
          state_nxt = DISP;
      end
      default: if (acc_cnt == 4'd1) state_nxt = IDLE;
    endcase
  end

  // Write enable rises one cycle early so address and data are held past the WE edge.
  always_comb begin
    _vram_oe      = 1'b1;
    _vram_we      = 1'b1;
    vram_wdata_en = 1'b0;
    case (state)
      DISP, CPU_RD: _vram_oe = 1'b0;
      CPU_WR: begin
        vram_wdata_en = 1'b1;
        _vram_we      = (acc_cnt == 4'd1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt    <= 4'd0;
      cpu_pend   <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= 8'd0;
      cpu_ready  <= 1'b0;
      cpu_rdata  <= 8'd0;
      disp_ack   <= 1'b0;
      disp_valid <= 1'b0;
      disp_data  <= 8'd0;
    end else begin
      disp_ack   <= disp_grant;
      disp_valid <= 1'b0;

      if (disp_grant || cpu_grant) acc_cnt <= 4'(ACC_CYC);
      else if (state != IDLE)      acc_cnt <= acc_cnt - 4'd1;

      if (disp_grant) vram_addr <= {plane, disp_addr};
      if (cpu_grant)  vram_addr <= cpu_addr;
      if (cpu_grant && (state_nxt == CPU_WR)) vram_wdata <= cpu_wdata;

      // A request withdrawn before grant is dropped; once in flight it always completes.
      if (acc_last && cpu_busy)
        cpu_pend <= 1'b0;
      else if (cpu_pend && _cpu_cs && !cpu_busy)
        cpu_pend <= 1'b0;
      else if (!cpu_pend && !_cpu_cs && !cpu_ready && !cpu_busy)
        cpu_pend <= 1'b1;

      if (acc_last && cpu_busy) cpu_ready <= 1'b1;
      else if (_cpu_cs)         cpu_ready <= 1'b0;

      if (acc_last && (state == CPU_RD)) cpu_rdata <= vram_rdata;

      if (acc_last && (state == DISP)) begin
        disp_valid <= 1'b1;
        disp_data  <= vram_rdata;
      end
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter with a clocked SRAM model and expectation queues.
module tb_vram_arbiter;
  localparam int ADDR_W   = 16;
  localparam int ACC_CYC  = 2;
  localparam int MAX_WAIT = 24;

  logic              clk = 1'b0;
  logic              reset;
  logic              plane, blank, disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_ack, disp_valid;
  logic [7:0]        disp_data;
  logic              _cpu_cs, _cpu_wr;
  logic [ADDR_W:0]   cpu_addr;
  logic [7:0]        cpu_wdata, cpu_rdata;
  logic              cpu_ready;
  logic [ADDR_W:0]   vram_addr;
  logic [7:0]        vram_wdata, vram_rdata;
  logic              vram_wdata_en, _vram_oe, _vram_we;

  int checks = 0;
  int passes = 0;

  logic [7:0]  rd_q[$];
  logic [7:0]  disp_q[$];
  logic [24:0] wr_q[$];

  // SRAM model: writes commit on any clock edge where WE is low.
  logic [7:0]      mem [0:(1<<(ADDR_W+1))-1];
  int              wr_count = 0;
  logic            pre_en = 1'b0;
  logic [ADDR_W:0] pre_addr = '0;
  logic [7:0]      pre_dat = 8'd0;

  assign vram_rdata = mem[vram_addr];

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_dat;
    if (!_vram_we) begin
      mem[vram_addr] <= vram_wdata;
      wr_count <= wr_count + 1;
    end
  end

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(ADDR_W), .ACC_CYC(ACC_CYC), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .plane(plane), .blank(blank), .disp_req(disp_req),
    .disp_addr(disp_addr), .disp_ack(disp_ack), .disp_valid(disp_valid), .disp_data(disp_data),
    ._cpu_cs(_cpu_cs), ._cpu_wr(_cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
    .vram_wdata_en(vram_wdata_en), .vram_rdata(vram_rdata), ._vram_oe(_vram_oe), ._vram_we(_vram_we)
  );

  task automatic preload(input logic [ADDR_W:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_dat = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic test_reset;
    logic [46:0] got;
    logic [46:0] exp;
    exp = {17'h0, 8'h0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0, 1'b0, 1'b0, 8'h0};
    repeat (2) @(negedge clk);
    got = {vram_addr, vram_wdata, vram_wdata_en, _vram_oe, _vram_we, cpu_ready,
           cpu_rdata, disp_ack, disp_valid, disp_data};
    checks++;
    if (got !== exp) $display("FAIL reset_outputs: got %h want %h", got, exp); else passes++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    got = {vram_addr, vram_wdata, vram_wdata_en, _vram_oe, _vram_we, cpu_ready,
           cpu_rdata, disp_ack, disp_valid, disp_data};
    checks++;
    if (got !== exp) $display("FAIL idle_after_reset: got %h want %h", got, exp); else passes++;
  endtask

  task automatic test_cpu_read;
    int g, r, oe_n;
    logic addr_bad;
    logic [7:0] e;
    preload(17'h01234, 8'h5A);
    rd_q.push_back(8'h5A);
    cpu_addr = 17'h01234; _cpu_wr = 1'b1; _cpu_cs = 1'b0;
    g = -1; r = -1; oe_n = 0; addr_bad = 1'b0;
    for (int i = 1; i <= 20 && r < 0; i++) begin
      @(negedge clk);
      if (!_vram_oe) begin
        oe_n++;
        if (g < 0) g = i;
        if (vram_addr !== 17'h01234) addr_bad = 1'b1;
      end
      if (cpu_ready) r = i;
    end
    checks++;
    if (r < 0) $display("FAIL rd_timeout: cpu_ready never rose"); else passes++;
    checks++;
    if (oe_n !== ACC_CYC) $display("FAIL rd_oe_len: got %0d want %0d", oe_n, ACC_CYC); else passes++;
    checks++;
    if (addr_bad) $display("FAIL rd_addr: got %h want 01234", vram_addr); else passes++;
    checks++;
    if (r - g !== ACC_CYC) $display("FAIL rd_latency: got %0d want %0d", r - g, ACC_CYC); else passes++;
    e = rd_q.pop_front();
    checks++;
    if (cpu_rdata !== e) $display("FAIL rd_data: got %h want %h", cpu_rdata, e); else passes++;
    _cpu_cs = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b0) $display("FAIL rd_ready_drop: got %b want 0", cpu_ready); else passes++;
  endtask

  task automatic test_cpu_write;
    int r, we_n;
    logic held;
    logic [24:0] e;
    wr_q.push_back({17'h08000, 8'hA5});
    cpu_addr = 17'h08000; cpu_wdata = 8'hA5; _cpu_wr = 1'b0; _cpu_cs = 1'b0;
    r = -1; we_n = 0; held = 1'b1;
    for (int i = 1; i <= 20 && r < 0; i++) begin
      @(negedge clk);
      if (!_vram_we) we_n++;
      if (cpu_ready) r = i;
    end
    checks++;
    if (r < 0) $display("FAIL wr_timeout: cpu_ready never rose"); else passes++;
    checks++;
    if (we_n !== ACC_CYC - 1) $display("FAIL wr_we_len: got %0d want %0d", we_n, ACC_CYC - 1); else passes++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (cpu_ready !== 1'b1 || !_vram_we) held = 1'b0;
    end
    checks++;
    if (!held) $display("FAIL wr_ready_hold: got drop or rewrite want ready held"); else passes++;
    _cpu_cs = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b0) $display("FAIL wr_ready_drop: got %b want 0", cpu_ready); else passes++;
    e = wr_q.pop_front();
    checks++;
    if (mem[e[24:8]] !== e[7:0]) $display("FAIL wr_mem: got %h want %h", mem[e[24:8]], e[7:0]); else passes++;
  endtask

  task automatic test_disp_priority;
    int a, v, w;
    logic [ADDR_W:0] ack_addr;
    logic [7:0] got_d, e;
    logic [24:0] we;
    preload(17'h10040, 8'hC3);
    disp_q.push_back(8'hC3);
    wr_q.push_back({17'h00100, 8'h77});
    plane = 1'b1; disp_addr = 16'h0040; disp_req = 1'b1;
    cpu_addr = 17'h00100; cpu_wdata = 8'h77; _cpu_wr = 1'b0; _cpu_cs = 1'b0;
    a = -1; v = -1; w = -1; ack_addr = '0; got_d = 8'h00;
    for (int i = 1; i <= 30 && !cpu_ready; i++) begin
      @(negedge clk);
      if (disp_ack && a < 0) begin a = i; ack_addr = vram_addr; disp_req = 1'b0; end
      if (disp_valid && v < 0) begin v = i; got_d = disp_data; end
      if (vram_wdata_en && w < 0) w = i;
    end
    checks++;
    if (a !== 1) $display("FAIL pri_disp_first: got ack at %0d want 1", a); else passes++;
    checks++;
    if (ack_addr !== 17'h10040) $display("FAIL pri_addr: got %h want 10040", ack_addr); else passes++;
    checks++;
    if (v !== a + ACC_CYC) $display("FAIL pri_valid_cycle: got %0d want %0d", v, a + ACC_CYC); else passes++;
    e = disp_q.pop_front();
    checks++;
    if (got_d !== e) $display("FAIL pri_disp_data: got %h want %h", got_d, e); else passes++;
    checks++;
    if (w !== a + ACC_CYC + 1) $display("FAIL pri_cpu_after_idle: got %0d want %0d", w, a + ACC_CYC + 1); else passes++;
    _cpu_cs = 1'b1;
    @(negedge clk);
    we = wr_q.pop_front();
    checks++;
    if (mem[we[24:8]] !== we[7:0]) $display("FAIL pri_wr_mem: got %h want %h", mem[we[24:8]], we[7:0]); else passes++;
  endtask

  task automatic test_blank;
    int r, a, acks;
    logic [7:0] e;
    preload(17'h02222, 8'h3C);
    rd_q.push_back(8'h3C);
    blank = 1'b1; disp_req = 1'b1; plane = 1'b0; disp_addr = 16'h0500;
    cpu_addr = 17'h02222; _cpu_wr = 1'b1; _cpu_cs = 1'b0;
    r = -1; a = -1; acks = 0;
    for (int i = 1; i <= 20 && r < 0; i++) begin
      @(negedge clk);
      if (disp_ack) acks++;
      if (cpu_ready) r = i;
    end
    checks++;
    if (r < 0) $display("FAIL blank_cpu_timeout: cpu_ready never rose"); else passes++;
    e = rd_q.pop_front();
    checks++;
    if (cpu_rdata !== e) $display("FAIL blank_rd_data: got %h want %h", cpu_rdata, e); else passes++;
    _cpu_cs = 1'b1;
    @(negedge clk);
    if (disp_ack) acks++;
    checks++;
    if (acks !== 0) $display("FAIL blank_no_ack: got %0d acks want 0", acks); else passes++;
    blank = 1'b0;
    for (int i = 1; i <= 10 && a < 0; i++) begin
      @(negedge clk);
      if (disp_ack) begin a = i; disp_req = 1'b0; end
    end
    checks++;
    if (a !== 1) $display("FAIL blank_release_ack: got %0d want 1", a); else passes++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_starve;
    int g, r;
    logic [7:0] e;
    rd_q.push_back(8'h5A);
    plane = 1'b0; disp_addr = 16'h0300; disp_req = 1'b1; blank = 1'b0;
    cpu_addr = 17'h01234; _cpu_wr = 1'b1; _cpu_cs = 1'b0;
    g = -1; r = -1;
`ifdef VRAM_CPU_STARVE_GUARD_EN
    for (int i = 1; i <= 60 && g < 0; i++) begin
      @(negedge clk);
      if (!_vram_oe && vram_addr === 17'h01234) g = i;
    end
    checks++;
    if (g < MAX_WAIT || g > MAX_WAIT + ACC_CYC + 4)
      $display("FAIL starve_guard_grant: got cycle %0d want %0d..%0d", g, MAX_WAIT, MAX_WAIT + ACC_CYC + 4);
    else passes++;
`else
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (!_vram_oe && vram_addr === 17'h01234 && g < 0) g = i;
    end
    checks++;
    if (g >= 0) $display("FAIL starve_no_grant: got grant at %0d want none in 200", g); else passes++;
`endif
    disp_req = 1'b0;
    for (int i = 1; i <= 20 && r < 0; i++) begin
      @(negedge clk);
      if (cpu_ready) r = i;
    end
    e = rd_q.pop_front();
    checks++;
    if (r < 0 || cpu_rdata !== e) $display("FAIL starve_rd_data: got %h want %h", cpu_rdata, e); else passes++;
    _cpu_cs = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_write;
    logic seen;
    int wc;
    logic [3:0] got;
    preload(17'h00200, 8'h11);
    cpu_addr = 17'h00200; cpu_wdata = 8'hEE; _cpu_wr = 1'b0; _cpu_cs = 1'b0;
    seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (!_vram_we) seen = 1'b1;
    end
    checks++;
    if (!seen) $display("FAIL rst_wr_timeout: write never started"); else passes++;
    wc = wr_count;
    reset = 1'b1;
    #1;
    got = {_vram_we, vram_wdata_en, cpu_ready, _vram_oe};
    checks++;
    if (got !== 4'b1001) $display("FAIL rst_mid_outputs: got %b want 1001", got); else passes++;
    _cpu_cs = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (wr_count !== wc) $display("FAIL rst_no_write: got %0d writes want %0d", wr_count, wc); else passes++;
    checks++;
    if (mem[17'h00200] !== 8'h11) $display("FAIL rst_mem_intact: got %h want 11", mem[17'h00200]); else passes++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; plane = 1'b0; blank = 1'b0; disp_req = 1'b0; disp_addr = '0;
    _cpu_cs = 1'b1; _cpu_wr = 1'b1; cpu_addr = '0; cpu_wdata = 8'h00;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_disp_priority();
    test_blank();
    test_starve();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
